// File: rtl/fifo18kx2_rd_arbiter.sv
// Read-side arbiter for the two halves of a FIFO18KX2: issues reads with a
// burst-limited round-robin and merges both streams into one valid/ready output.
module fifo18kx2_rd_arbiter #(
    parameter int DATA_WIDTH = 18,
    parameter int MAX_BURST  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  EMPTY1,
    input  logic                  EMPTY2,
    input  logic                  UNDERFLOW1,
    input  logic                  UNDERFLOW2,
    input  logic [DATA_WIDTH-1:0] RD_DATA1,
    input  logic [DATA_WIDTH-1:0] RD_DATA2,
    output logic                  RD_EN1,
    output logic                  RD_EN2,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_SRC,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic                  ERR
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
    localparam logic          SRC_F1    = 1'b0;
    localparam logic          SRC_F2    = 1'b1;

    logic                  run;
    logic                  pend;
    logic                  pend_src;
    logic                  last_grant;
    logic [CW-1:0]         burst_cnt;
    logic [1:0]            occ;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_src  [2];

    logic pop;
    logic room;
    logic grant;
    logic stay;
    logic pick;

    assign M_VALID = (occ != 2'd0);
    assign M_DATA  = buf_data[rd_ptr];
    assign M_SRC   = buf_src[rd_ptr];

    // Read enables are combinational so a read can issue in the same cycle a
    // word pops, which is what sustains one word per cycle through the buffer.
    // NOTE: every output of this block is assigned on every path, so no latch.
    always_comb begin
        pop   = M_VALID & M_READY;
        room  = ({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop});
        grant = run & ENABLE & room & ~(EMPTY1 & EMPTY2);
        // burst_cnt == 0 means nothing granted since reset: hand the first
        // contested grant to the side opposite last_grant, i.e. FIFO1.
        stay  = (burst_cnt != '0) && (burst_cnt < BURST_MAX);
        if (!EMPTY1 && !EMPTY2) begin
            pick = stay ? last_grant : ~last_grant;
        end else begin
            pick = EMPTY1 ? SRC_F2 : SRC_F1;
        end
        RD_EN1 = grant & (pick == SRC_F1);
        RD_EN2 = grant & (pick == SRC_F2);
    end

    // NOTE: state updates use <= so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            run         <= 1'b0;
            pend        <= 1'b0;
            pend_src    <= SRC_F1;
            last_grant  <= SRC_F2;
            burst_cnt   <= '0;
            occ         <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            ERR         <= 1'b0;
            // NOTE: the two buffer entries are reset because M_DATA/M_SRC
            // read them directly and must show zero during reset.
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_src[0]  <= 1'b0;
            buf_src[1]  <= 1'b0;
        end else begin
            run  <= 1'b1;
            ERR  <= ERR | UNDERFLOW1 | UNDERFLOW2;
            pend <= grant;
            if (grant) begin
                pend_src   <= pick;
                last_grant <= pick;
                if (pick != last_grant) begin
                    burst_cnt <= CW'(1);
                end else if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + CW'(1);
                end
            end
            // Read data arrives one cycle after the enable; land it at the tail.
            if (pend) begin
                buf_data[wr_ptr] <= pend_src ? RD_DATA2 : RD_DATA1;
                buf_src[wr_ptr]  <= pend_src;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, pend} - {1'b0, pop};
        end
    end

endmodule

// File: doc/fifo18kx2_rd_arbiter.md
FIFO18KX2_RD_ARBITER -- requirements
Module: fifo18kx2_rd_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 18, giving the width of each read-data bus and of M_DATA; legal values are 9 and 18.
REQ-002 The block SHALL have parameter MAX_BURST, default 1, giving the maximum consecutive grants to one FIFO while the other is non-empty; legal range is 1..16.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ENABLE, input, 1 bit: permits issue of new reads.
REQ-006 The block SHALL have ports EMPTY1 and EMPTY2, input, 1 bit each: empty flags of FIFO1 and FIFO2.
REQ-007 The block SHALL have ports UNDERFLOW1 and UNDERFLOW2, input, 1 bit each: underflow flags of FIFO1 and FIFO2.
REQ-008 The block SHALL have ports RD_DATA1 and RD_DATA2, input, DATA_WIDTH bits each: FIFO read data, valid one cycle after the read enable.
REQ-009 The block SHALL have ports RD_EN1 and RD_EN2, output, 1 bit each: read enables to FIFO1 and FIFO2.
REQ-010 The block SHALL have port M_DATA, output, DATA_WIDTH bits: merged output data.
REQ-011 The block SHALL have port M_SRC, output, 1 bit: source of M_DATA, 0 = FIFO1, 1 = FIFO2.
REQ-012 The block SHALL have port M_VALID, output, 1 bit: M_DATA and M_SRC are valid.
REQ-013 The block SHALL have port M_READY, input, 1 bit: the downstream accepts M_DATA.
REQ-014 The block SHALL have port ERR, output, 1 bit: sticky underflow error.

Function
REQ-015 The block SHALL drain both halves of a FIFO18KX2 into one M_* stream, fixed read latency 1.
REQ-016 A transfer SHALL occur on a cycle with M_VALID=1 and M_READY=1 (pop).
REQ-017 M_DATA and M_SRC SHALL hold stable while M_VALID=1 and M_READY=0.
REQ-018 Output buffering SHALL be a 2-entry in-order buffer; occ (0..2) is its occupancy.
REQ-019 pend SHALL be 1 in the cycle after any RD_EN assertion, capturing the granted source.
REQ-020 A read MAY issue only if ENABLE=1 and occ + pend - pop < 2.
REQ-021 RD_ENn SHALL never assert while EMPTYn=1, and RD_EN1 and RD_EN2 SHALL never assert in the same cycle.
REQ-022 With exactly one FIFO non-empty and issue allowed, the block SHALL grant that FIFO.
REQ-023 With both FIFOs non-empty and issue allowed, the block SHALL grant last_grant while burst_cnt < MAX_BURST, otherwise the other FIFO.
REQ-024 On every grant, burst_cnt SHALL become 1 when the source changes and otherwise burst_cnt+1, saturating at MAX_BURST.
REQ-025 Each grant SHALL update last_grant.
REQ-026 In the cycle after a read, RD_DATAn and its source SHALL be written to the buffer tail.
REQ-027 Simultaneous pop and write SHALL leave occ unchanged.
REQ-028 Data SHALL leave in grant order, with no loss or duplication.
REQ-029 Sustained throughput SHALL be one word per cycle when M_READY=1 and data is available.
REQ-030 Latency SHALL be 2 cycles: RD_EN at cycle t gives M_VALID at t+2 if the buffer was empty.
REQ-031 On ENABLE deassertion, no new RD_EN SHALL issue; in-flight reads and buffered words SHALL still complete.
REQ-032 ERR SHALL set on the cycle after UNDERFLOW1 or UNDERFLOW2 is high and hold until reset.
REQ-033 ERR SHALL NOT alter arbitration.

Reset
REQ-034 RESET=0 SHALL immediately force RD_EN1, RD_EN2, M_VALID, M_DATA, M_SRC and ERR to 0.
REQ-035 RESET=0 SHALL immediately set occ=0, pend=0, burst_cnt=0 and last_grant=FIFO2.
REQ-036 After reset, the first contested grant SHALL go to FIFO1.
REQ-037 Reset mid-transfer SHALL discard in-flight and buffered words without producing output.
REQ-038 Outputs SHALL leave reset values only on the first CLK edge after RESET rises.

Verification
REQ-039 The bench SHALL cover: MAX_BURST=1, both FIFOs hold 4 words, M_READY=1 -> M_SRC 0,1,0,1,0,1,0,1 on consecutive cycles, first M_VALID 2 cycles after the first RD_EN1.
REQ-040 The bench SHALL cover: MAX_BURST=3, both non-empty -> source pattern 0,0,0,1,1,1,0,...
REQ-041 The bench SHALL cover: M_READY=0 for 10 cycles with both non-empty -> exactly 2 reads issued, occ=2, data stable; on M_READY=1, 1 word/cycle with no gaps.
REQ-042 The bench SHALL cover: FIFO1 only, holding 1 word -> a single RD_EN1 pulse, EMPTY1 rises, no further RD_EN1, M_DATA equals the word with M_SRC=0.
REQ-043 The bench SHALL cover: ENABLE dropped the cycle after RD_EN2 -> that word still emitted, no further RD_EN.
REQ-044 The bench SHALL cover: UNDERFLOW2 pulse -> ERR=1 the next cycle and held; RESET low mid-stream -> all outputs 0 asynchronously, first post-reset contested grant to FIFO1.
